// File: rtl/ram_mp_if.sv
// Bus bundle for ram_mp: CPU port, arbitrated aux read channels and clear-engine control.
interface ram_mp_if #(
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 15,
    parameter int unsigned NRD = 2
);
    logic [AW-1:0]     i_addr;
    logic [DW-1:0]     i_data;
    logic              i_write;
    logic [DW-1:0]     o_data;
    logic [NRD-1:0]    i_rd_req;
    logic [NRD*AW-1:0] i_rd_addr;
    logic [NRD-1:0]    o_rd_gnt;
    logic [NRD-1:0]    o_rd_valid;
    logic [NRD*DW-1:0] o_rd_data;
    logic              i_clr_start;
    logic              o_clr_busy;
    logic              o_clr_done;
    logic              o_err;

    // Requester side (CPU, VGA fetch, sprite readers, clear control)
    modport master (
        output i_addr, i_data, i_write, i_rd_req, i_rd_addr, i_clr_start,
        input  o_data, o_rd_gnt, o_rd_valid, o_rd_data, o_clr_busy, o_clr_done, o_err
    );

    // Memory side
    modport slave (
        input  i_addr, i_data, i_write, i_rd_req, i_rd_addr, i_clr_start,
        output o_data, o_rd_gnt, o_rd_valid, o_rd_data, o_clr_busy, o_clr_done, o_err
    );
endinterface

// File: rtl/ram_mp.sv
// Hack data RAM: CPU read/write port A, round-robin arbitrated aux reads on port B,
// out-of-range detection and a hardware clear engine sharing port A with the CPU.
module ram_mp #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 15,
    parameter int unsigned DEPTH    = 24576,
    parameter int unsigned NRD      = 2,
    parameter int unsigned CLR_BASE = 16384,
    parameter int unsigned CLR_LEN  = 8192
) (
    input logic    i_clk,
    input logic    i_rst,
    ram_mp_if.slave bus
);
    localparam int unsigned PW = (NRD > 1) ? $clog2(NRD) : 1;
    localparam logic [AW-1:0] CLR_FIRST = AW'(CLR_BASE);
    localparam logic [AW-1:0] CLR_LAST  = AW'(CLR_BASE + CLR_LEN - 1);

    // Parameter sanity: clear region inside memory, channel count bounded
    if (CLR_BASE + CLR_LEN > DEPTH) begin : g_bad_clr
        $error("ram_mp: clear region exceeds DEPTH");
    end
    if (NRD < 1 || NRD > 8) begin : g_bad_nrd
        $error("ram_mp: NRD must be 1..8");
    end
    if (DEPTH > (32'd1 << AW)) begin : g_bad_depth
        $error("ram_mp: DEPTH exceeds address space");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    logic [DW-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]     o_data_q, o_data_d;
    logic [NRD-1:0]    rd_valid_q, rd_valid_d;
    logic [NRD*DW-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;

    logic              a_in_range_c;
    logic              cpu_wr_c;
    logic              clr_wr_c;
    logic [NRD-1:0]    gnt_c;
    logic [PW-1:0]     win_c;
    logic              found_c;
    logic              b_oob_c;

    // Port A ownership: CPU writes win, engine writes only on cycles without i_write
    always_comb begin
        a_in_range_c = (32'(bus.i_addr) < DEPTH);
        cpu_wr_c     = bus.i_write && a_in_range_c;
        clr_wr_c     = (state_q == ST_CLEAR) && !bus.i_write;
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge i_clk) begin
        if (cpu_wr_c) begin
            mem[bus.i_addr] <= bus.i_data;
        end else if (clr_wr_c) begin
            mem[clr_ptr_q] <= '0;
        end
    end

    // Round-robin arbiter: scan upward from rr pointer, first requester wins
    always_comb begin
        logic [PW-1:0] idx;
        gnt_c    = '0;
        win_c    = '0;
        found_c  = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            idx = PW'((32'(rr_ptr_q) + i) % NRD);
            if (!found_c && bus.i_rd_req[idx]) begin
                found_c    = 1'b1;
                gnt_c[idx] = 1'b1;
                win_c      = idx;
            end
        end
        if (i_rst) begin
            gnt_c   = '0;
            found_c = 1'b0;
        end
        rr_ptr_d = found_c ? PW'((32'(win_c) + 1) % NRD) : rr_ptr_q;
    end

    // Port B read of the granted channel; pre-edge array value gives read-first behaviour
    always_comb begin
        logic [AW-1:0] addr_k;
        rd_valid_d = gnt_c;
        rd_data_d  = rd_data_q;
        b_oob_c    = 1'b0;
        addr_k     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            addr_k = bus.i_rd_addr[k*AW +: AW];
            if (gnt_c[k]) begin
                if (32'(addr_k) < DEPTH) begin
                    rd_data_d[k*DW +: DW] = mem[addr_k];
                end else begin
                    rd_data_d[k*DW +: DW] = '0;
                    b_oob_c               = 1'b1;
                end
            end
        end
    end

    // CPU read data and sticky out-of-range flag
    always_comb begin
        o_data_d = a_in_range_c ? mem[bus.i_addr] : '0;
        err_d    = err_q || !a_in_range_c || b_oob_c;
    end

    // Clear engine next-state and registered status
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = CLR_FIRST;
                end
            end
            ST_CLEAR: begin
                if (!bus.i_write) begin
                    if (clr_ptr_q == CLR_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        clr_ptr_d = clr_ptr_q + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rr_ptr_q   <= '0;
            o_data_q   <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rr_ptr_q   <= rr_ptr_d;
            o_data_q   <= o_data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    // Drive the bus outputs
    always_comb begin
        bus.o_data     = o_data_q;
        bus.o_rd_gnt   = gnt_c;
        bus.o_rd_valid = rd_valid_q;
        bus.o_rd_data  = rd_data_q;
        bus.o_clr_busy = busy_q;
        bus.o_clr_done = done_q;
        bus.o_err      = err_q;
    end
endmodule

// File: tb/tb_ram_mp.sv
// Directed self-checking bench for ram_mp.
module tb_ram_mp;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 15;
    localparam int unsigned NRD = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ram_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    ram_mp #(
        .DW(DW), .AW(AW), .DEPTH(24576), .NRD(NRD),
        .CLR_BASE(16384), .CLR_LEN(8192)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_addr  = a;
        bus.i_data  = d;
        bus.i_write = 1'b1;
        tick();
        bus.i_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        bus.i_addr  = a;
        bus.i_write = 1'b0;
        tick();
        d = bus.o_data;
    endtask

    initial begin
        logic [DW-1:0] rdat;
        logic [1:0]    exp_g;
        logic [DW-1:0] exp_d;
        int            cnt;
        int            nz;
        int            dones;

        rst             = 1'b1;
        bus.i_addr      = '0;
        bus.i_data      = '0;
        bus.i_write     = 1'b0;
        bus.i_rd_req    = 2'b11;
        bus.i_rd_addr   = '0;
        bus.i_clr_start = 1'b0;

        // Reset state, grants suppressed while reset is high
        tick();
        tick();
        check_eq("rst_o_data",   32'(bus.o_data), 32'h0);
        check_eq("rst_rd_valid", 32'(bus.o_rd_valid), 32'h0);
        check_eq("rst_rd_data",  32'(bus.o_rd_data), 32'h0);
        check_eq("rst_busy",     32'(bus.o_clr_busy), 32'h0);
        check_eq("rst_done",     32'(bus.o_clr_done), 32'h0);
        check_eq("rst_err",      32'(bus.o_err), 32'h0);
        check_eq("rst_gnt",      32'(bus.o_rd_gnt), 32'h0);
        bus.i_rd_req = 2'b00;
        rst          = 1'b0;
        tick();

        // Test 1: write then read, plus read-first on same-address write
        cpu_wr(15'h0000, 16'h0F0F);
        cpu_wr(15'h0005, 16'h1234);
        cpu_rd(15'h0005, rdat);
        check_eq("t1_read", 32'(rdat), 32'h1234);
        cpu_wr(15'h0005, 16'h5678);
        check_eq("t1_read_first", 32'(bus.o_data), 32'h1234);
        cpu_rd(15'h0005, rdat);
        check_eq("t1_new_word", 32'(rdat), 32'h5678);

        // Test 2: both channels request every cycle, grants alternate
        cpu_wr(15'h0010, 16'hAAAA);
        cpu_wr(15'h0020, 16'h5555);
        bus.i_rd_addr = {15'h0020, 15'h0010};
        bus.i_rd_req  = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
            #1;
            check_eq("t2_gnt", 32'(bus.o_rd_gnt), 32'(exp_g));
            tick();
            check_eq("t2_valid", 32'(bus.o_rd_valid), 32'(exp_g));
            if (i % 2 == 0) check_eq("t2_ch0_data", 32'(bus.o_rd_data[0 +: DW]), 32'(exp_d));
            else            check_eq("t2_ch1_data", 32'(bus.o_rd_data[DW +: DW]), 32'(exp_d));
        end
        bus.i_rd_req = 2'b00;
        tick();
        check_eq("t2_valid_idle", 32'(bus.o_rd_valid), 32'h0);

        // Test 3: same-edge CPU write and port B read return the old word
        cpu_wr(15'h4000, 16'h1111);
        bus.i_rd_addr = {15'h0000, 15'h4000};
        bus.i_rd_req  = 2'b01;
        bus.i_addr    = 15'h4000;
        bus.i_data    = 16'hBEEF;
        bus.i_write   = 1'b1;
        #1;
        check_eq("t3_gnt0", 32'(bus.o_rd_gnt), 32'h1);
        tick();
        bus.i_write = 1'b0;
        check_eq("t3_valid0", 32'(bus.o_rd_valid), 32'h1);
        check_eq("t3_old_word", 32'(bus.o_rd_data[0 +: DW]), 32'h1111);
        #1;
        check_eq("t3_gnt_b2b", 32'(bus.o_rd_gnt), 32'h1);
        tick();
        check_eq("t3_valid_b2b", 32'(bus.o_rd_valid), 32'h1);
        check_eq("t3_new_word", 32'(bus.o_rd_data[0 +: DW]), 32'hBEEF);
        bus.i_rd_req = 2'b00;

        // Test 4: fill screen, clear with no CPU writes
        cpu_wr(15'h3FFF, 16'h7777);
        for (int a = 16384; a < 24576; a++) cpu_wr(AW'(a), 16'hFFFF);
        bus.i_clr_start = 1'b1;
        tick();
        bus.i_clr_start = 1'b0;
        cnt = 0;
        while (bus.o_clr_busy && cnt < 20000) begin
            cnt++;
            tick();
        end
        check_eq("t4_busy_cycles", 32'(cnt), 32'd8192);
        check_eq("t4_done_pulse", 32'(bus.o_clr_done), 32'h1);
        tick();
        check_eq("t4_done_end", 32'(bus.o_clr_done), 32'h0);
        check_eq("t4_busy_end", 32'(bus.o_clr_busy), 32'h0);
        nz = 0;
        for (int a = 16384; a < 24576; a++) begin
            cpu_rd(AW'(a), rdat);
            if (rdat !== 16'h0000) nz++;
        end
        check_eq("t4_region_zero", 32'(nz), 32'h0);
        cpu_rd(15'h3FFF, rdat);
        check_eq("t4_below_kept", 32'(rdat), 32'h7777);
        check_eq("t4_no_err", 32'(bus.o_err), 32'h0);

        // Test 5: 100 CPU writes during clear stretch it by 100 cycles
        bus.i_clr_start = 1'b1;
        tick();
        bus.i_clr_start = 1'b0;
        cnt = 0;
        while (bus.o_clr_busy && cnt < 20000) begin
            bus.i_addr  = 15'h5F00;
            bus.i_data  = 16'hABCD;
            bus.i_write = (cnt < 100);
            cnt++;
            tick();
        end
        bus.i_write = 1'b0;
        check_eq("t5_busy_cycles", 32'(cnt), 32'd8292);
        check_eq("t5_done_pulse", 32'(bus.o_clr_done), 32'h1);
        cpu_rd(15'h5F00, rdat);
        check_eq("t5_ahead_overwritten", 32'(rdat), 32'h0);

        // Test 5b: reset mid-clear aborts without done pulse
        cpu_wr(15'h4000, 16'h8888);
        cpu_wr(15'h5FFF, 16'h9999);
        bus.i_clr_start = 1'b1;
        tick();
        bus.i_clr_start = 1'b0;
        check_eq("t5_busy_start", 32'(bus.o_clr_busy), 32'h1);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        check_eq("t5_abort_busy", 32'(bus.o_clr_busy), 32'h0);
        check_eq("t5_abort_done", 32'(bus.o_clr_done), 32'h0);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.o_clr_done) dones++;
        end
        check_eq("t5_no_done_after", 32'(dones), 32'h0);
        cpu_rd(15'h4000, rdat);
        check_eq("t5_first_cleared", 32'(rdat), 32'h0);
        cpu_rd(15'h5FFF, rdat);
        check_eq("t5_tail_kept", 32'(rdat), 32'h9999);

        // Test 6: out-of-range write is dropped and sets sticky error
        check_eq("t6_err_before", 32'(bus.o_err), 32'h0);
        cpu_wr(15'h6000, 16'hDEAD);
        check_eq("t6_err_set", 32'(bus.o_err), 32'h1);
        check_eq("t6_oob_read", 32'(bus.o_data), 32'h0);
        cpu_rd(15'h0000, rdat);
        check_eq("t6_no_alias", 32'(rdat), 32'h0F0F);
        repeat (5) tick();
        check_eq("t6_err_sticky", 32'(bus.o_err), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("t6_err_cleared", 32'(bus.o_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
